// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package mp_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mp_state_t;

  // Zero-length requests still produce one word; oversize requests saturate.
  function automatic int unsigned clamp_len(input int unsigned l, input int unsigned nmax);
    if (l == 0)         return 1;
    else if (l > nmax)  return nmax;
    else                return l;
  endfunction

endpackage

// File: rtl/mp_word_add.sv
// Combinational W-bit word adder with carry-in/carry-out.
module mp_word_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract sequencer: streams LSW-first word pairs through
// one word adder, carry held in a register. Optional MP_ADD_ZERO_FLAG_EN adds
// a sticky all-words-zero output.
module multiword_add_seq
  import mp_add_pkg::*;
#(
  parameter int W     = 32,
  parameter int N_MAX = 8,
  parameter int LEN_W = $clog2(N_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     s,
  output logic             out_last,
  output logic             cout,
  output logic             of,
  output logic             busy,
  output logic             done
`ifdef MP_ADD_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  mp_state_t        state, state_nx;
  logic [LEN_W-1:0] len_q, cnt;
  logic             sub_q, carry;
  logic [W-1:0]     yp, sum;
  logic             c, acc, last, ovf;

  assign yp   = y ^ {W{sub_q}};
  assign last = (cnt == len_q - LEN_W'(1));
  assign acc  = in_valid & in_ready;
  assign ovf  = ~(x[W-1] ^ yp[W-1]) & (x[W-1] ^ sum[W-1]);

  mp_word_add #(.W(W)) u_add (
    .a   (x),
    .b   (yp),
    .cin (carry),
    .s   (sum),
    .cout(c)
  );

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        busy     = 1'b1;
        in_ready = !out_valid | out_ready;
        if (acc && last) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_valid && out_ready && out_last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      sub_q     <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      s         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      cout      <= 1'b0;
      of        <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        len_q <= LEN_W'(clamp_len(32'(len), 32'(N_MAX)));
        sub_q <= sub;
        carry <= sub;   // +1 of the two's-complement negate
        cnt   <= '0;
      end
      // A new accept overwrites the output register even when it handshakes.
      if (acc) begin
        s         <= sum;
        carry     <= c;
        cnt       <= cnt + LEN_W'(1);
        out_valid <= 1'b1;
        out_last  <= last;
        if (last) begin
          cout <= c;
          of   <= ovf;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef MP_ADD_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      zero <= 1'b0;
    else if (state == IDLE && start) zero <= 1'b1;
    else if (acc)                    zero <= zero & (sum == '0);
  end
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed, table-driven bench for multiword_add_seq (optional MP_ADD_ZERO_FLAG_EN).
module tb_multiword_add_seq;

  localparam int W  = 32;
  localparam int NM = 8;
  localparam int LW = $clog2(NM + 1);

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, sub = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [LW-1:0] len = '0;
  logic [W-1:0]  x = '0, y = '0;
  logic          in_ready, out_valid, out_last, cout, of, busy, done;
  logic [W-1:0]  s;
`ifdef MP_ADD_ZERO_FLAG_EN
  logic          zero;
`endif

  int tests = 0, fails = 0;

  multiword_add_seq #(.W(W), .N_MAX(NM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .out_last(out_last),
    .cout(cout), .of(of), .busy(busy), .done(done)
`ifdef MP_ADD_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string                 nm;
    int                    len;
    bit                    sub;
    logic [NM-1:0][W-1:0]  x, y, es;
    int                    n;
    bit                    ecout, eof, ezero;
    int                    dcyc;
    logic [15:0]           rpat;
    bit                    poke;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input int l, input bit sb, input int n,
                              input bit ec, input bit eo, input bit ez, input int dc);
    vec_t v;
    v.nm = nm; v.len = l; v.sub = sb; v.n = n;
    v.ecout = ec; v.eof = eo; v.ezero = ez; v.dcyc = dc;
    v.x = '0; v.y = '0; v.es = '0; v.rpat = '1; v.poke = 1'b0;
    return v;
  endfunction

  // Drives one operation; inputs are always offered so the DUT alone decides word count.
  task automatic run_vec(input vec_t v);
    int sent, got, cyc, k, idx;
    bit fin, hold;
    logic [W-1:0] hs;
    sent = 0; got = 0; cyc = 0; k = 0; fin = 0; hold = 0; hs = '0;
    @(negedge clk);
    start = 1'b1; len = LW'(v.len); sub = v.sub; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk); start = 1'b0;
    chk({v.nm, " busy"}, W'(busy), W'(1));
    while (!fin && cyc < 64) begin
      if (done) begin
        chk({v.nm, " done_cycle"}, W'(cyc), W'(v.dcyc));
        chk({v.nm, " words_out"}, W'(got), W'(v.n));
        chk({v.nm, " words_in"}, W'(sent), W'(v.n));
        fin = 1;
      end else begin
        if (hold) begin
          chk({v.nm, " stall_valid"}, W'(out_valid), W'(1));
          chk({v.nm, " stall_s"}, s, hs);
        end
        if (v.poke && k == 1) begin
          start = 1'b1; len = LW'(NM); sub = ~v.sub;
        end else start = 1'b0;
        out_ready = (k < 16) ? v.rpat[k] : 1'b1;
        idx = (sent < NM) ? sent : NM - 1;
        in_valid = 1'b1; x = v.x[idx]; y = v.y[idx];
        #1;
        hold = out_valid && !out_ready;
        if (hold) begin
          hs = s;
          chk({v.nm, " in_ready_blocked"}, W'(in_ready), W'(0));
        end
        if (out_valid && out_ready) begin
          if (got < NM) chk($sformatf("%s s[%0d]", v.nm, got), s, v.es[got]);
          chk($sformatf("%s last[%0d]", v.nm, got), W'(out_last), W'(got == v.n - 1));
          if (got == v.n - 1) begin
            chk({v.nm, " cout"}, W'(cout), W'(v.ecout));
            chk({v.nm, " of"}, W'(of), W'(v.eof));
`ifdef MP_ADD_ZERO_FLAG_EN
            chk({v.nm, " zero"}, W'(zero), W'(v.ezero));
`endif
          end
          got++;
        end
        if (in_valid && in_ready) sent++;
        @(posedge clk); cyc++;
        @(negedge clk); k++;
      end
    end
    if (!fin) chk({v.nm, " done_timeout"}, W'(0), W'(1));
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk({v.nm, " done_pulse_end"}, W'(done), W'(0));
    chk({v.nm, " busy_end"}, W'(busy), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Hand-computed vectors
    vecs[0] = mk("add2", 2, 0, 2, 0, 0, 0, 4);
    vecs[0].x[0] = 32'hFFFFFFFF; vecs[0].y[0] = 32'h1; vecs[0].es[0] = 32'h0; vecs[0].es[1] = 32'h1;
    vecs[1] = mk("sub1_ovf", 1, 1, 1, 1, 1, 0, 3);
    vecs[1].x[0] = 32'h80000000; vecs[1].y[0] = 32'h1; vecs[1].es[0] = 32'h7FFFFFFF;
    vecs[2] = mk("add4_wrap", 4, 0, 4, 1, 0, 1, 6);
    for (int i = 0; i < 4; i++) vecs[2].x[i] = 32'hFFFFFFFF;
    vecs[2].y[0] = 32'h1;
    vecs[3] = mk("stall3", 3, 0, 3, 0, 0, 0, 7);
    vecs[3].x[0] = 1; vecs[3].x[1] = 2; vecs[3].x[2] = 3;
    vecs[3].y[0] = 10; vecs[3].y[1] = 20; vecs[3].y[2] = 30;
    vecs[3].es[0] = 11; vecs[3].es[1] = 22; vecs[3].es[2] = 33;
    vecs[3].rpat = 16'hFFF3;
    vecs[4] = mk("len0", 0, 0, 1, 0, 0, 0, 3);
    vecs[4].x[0] = 5; vecs[4].y[0] = 6; vecs[4].es[0] = 11; vecs[4].x[1] = 100;
    vecs[5] = mk("len_over", NM + 3, 0, NM, 0, 0, 0, NM + 2);
    for (int i = 0; i < NM; i++) begin
      vecs[5].x[i] = W'(i); vecs[5].y[i] = 32'h100; vecs[5].es[i] = W'(i + 256);
    end
    vecs[6] = mk("sub2_poke", 2, 1, 2, 1, 0, 0, 4);
    vecs[6].x[0] = 0; vecs[6].x[1] = 5; vecs[6].y[0] = 1; vecs[6].y[1] = 2;
    vecs[6].es[0] = 32'hFFFFFFFF; vecs[6].es[1] = 32'h2; vecs[6].poke = 1'b1;
    vecs[7] = mk("add1_ovf", 1, 0, 1, 0, 1, 0, 3);
    vecs[7].x[0] = 32'h7FFFFFFF; vecs[7].y[0] = 32'h1; vecs[7].es[0] = 32'h80000000;
    vecs[8] = mk("sub2_zero", 2, 1, 2, 1, 0, 1, 4);
    vecs[8].x[0] = 32'h12345678; vecs[8].x[1] = 32'h9ABCDEF0;
    vecs[8].y[0] = 32'h12345678; vecs[8].y[1] = 32'h9ABCDEF0;
    vecs[9] = mk("post_reset", 1, 0, 1, 0, 0, 0, 3);
    vecs[9].x[0] = 5; vecs[9].y[0] = 7; vecs[9].es[0] = 12;

    // Reset state
    #12;
    chk("rst out_valid", W'(out_valid), W'(0));
    chk("rst in_ready", W'(in_ready), W'(0));
    chk("rst s", s, W'(0));
    chk("rst flags", W'({out_last, cout, of, busy, done}), W'(0));
`ifdef MP_ADD_ZERO_FLAG_EN
    chk("rst zero", W'(zero), W'(0));
`endif
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset mid-operation, after two carry-producing words of a len=4 add
    @(negedge clk); start = 1'b1; len = LW'(4); sub = 1'b0;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; x = 32'hFFFFFFFF; y = 32'h1;
    @(negedge clk); x = 32'hFFFFFFFF; y = 32'h0;
    @(negedge clk); in_valid = 1'b0;
    chk("mid busy", W'(busy), W'(1));
    chk("mid out_valid", W'(out_valid), W'(1));
    rst_n = 1'b0; #1;
    chk("mid_rst out_valid", W'(out_valid), W'(0));
    chk("mid_rst in_ready", W'(in_ready), W'(0));
    chk("mid_rst s", s, W'(0));
    chk("mid_rst flags", W'({out_last, cout, of, busy, done}), W'(0));
    @(negedge clk);
    chk("mid_rst no_done", W'(done), W'(0));
    rst_n = 1'b1;
    run_vec(vecs[9]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
